// File: rtl/blob_pkg.sv
// Shared types and constants for the per-frame blob statistics engine.
package blob_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_PRESENT
    } state_t;

    // Empty bounding box: min starts at all-ones, max at zero; slice to width.
    localparam int                    BBOX_W_MAX     = 32;
    localparam logic [BBOX_W_MAX-1:0] BBOX_MIN_EMPTY = '1;
    localparam logic [BBOX_W_MAX-1:0] BBOX_MAX_EMPTY = '0;

    typedef struct packed {
        logic found;
        logic sat;
        logic empty;
    } ch_stats_t;

endpackage

// File: rtl/blob_stats_serial_divider.sv
// Restoring unsigned divider: one load cycle, then W iterations; quotient 0 for divisor 0.
module serial_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem;
    logic [W-1:0]  quo;
    logic [W-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          zero_div;
    logic [W:0]    shifted;
    logic [W:0]    diff;

    assign shifted  = {rem, quo[W-1]};
    assign diff     = shifted - {1'b0, dvs};
    assign quotient = zero_div ? '0 : quo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            zero_div <= 1'b0;
        end else if (start) begin
            rem      <= '0;
            quo      <= dividend;
            dvs      <= divisor;
            cnt      <= CW'(W);
            busy     <= 1'b1;
            done     <= 1'b0;
            zero_div <= (divisor == '0);
        end else if (busy) begin
            // diff[W] set means the trial subtraction went negative: restore.
            if (!diff[W]) begin
                rem <= diff[W-1:0];
                quo <= {quo[W-2:0], 1'b1};
            end else begin
                rem <= shifted[W-1:0];
                quo <= {quo[W-2:0], 1'b0};
            end
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/blob_stats.sv
// Per-channel hit count, coordinate sums and bbox per frame; centroids via one shared serial divider.
module blob_stats
    import blob_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int HW     = 11,
    parameter int VW     = 10,
    parameter int CNT_W  = 20,
    parameter int SUM_W  = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in_n,
    input  logic                  pix_valid_in,
    input  logic [HW-1:0]         hcount_in,
    input  logic [VW-1:0]         vcount_in,
    input  logic [NUM_CH-1:0]     hit_in,
    input  logic                  frame_done_in,
    input  logic [CNT_W-1:0]      min_count_in,
    input  logic                  stats_ready_in,
    output logic                  stats_valid_out,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic [NUM_CH*HW-1:0]  mean_x_out,
    output logic [NUM_CH*VW-1:0]  mean_y_out,
    output logic [NUM_CH*HW-1:0]  xmin_out,
    output logic [NUM_CH*HW-1:0]  xmax_out,
    output logic [NUM_CH*VW-1:0]  ymin_out,
    output logic [NUM_CH*VW-1:0]  ymax_out,
    output logic [NUM_CH-1:0]     found_out,
    output logic [NUM_CH-1:0]     sat_out,
    output logic [7:0]            drop_count_out,
    output logic                  busy_out
);

    localparam int NJ  = 2 * NUM_CH;
    localparam int JW  = $clog2(NJ);
    localparam int RW  = (HW > VW) ? HW : VW;
    localparam int SW1 = SUM_W + 1;
    localparam logic [JW-1:0] LAST_JOB = JW'(NJ - 1);

    state_t          state;
    logic [JW-1:0]   job;
    logic [JW-1:0]   ld_job;
    logic [JW-2:0]   ld_ch;
    logic            load_pending;

    logic [CNT_W-1:0] acc_cnt  [NUM_CH];
    logic [SUM_W-1:0] acc_sx   [NUM_CH];
    logic [SUM_W-1:0] acc_sy   [NUM_CH];
    logic [HW-1:0]    acc_xmin [NUM_CH];
    logic [HW-1:0]    acc_xmax [NUM_CH];
    logic [VW-1:0]    acc_ymin [NUM_CH];
    logic [VW-1:0]    acc_ymax [NUM_CH];
    logic             acc_sat  [NUM_CH];

    logic [CNT_W-1:0] nxt_cnt  [NUM_CH];
    logic [SUM_W-1:0] nxt_sx   [NUM_CH];
    logic [SUM_W-1:0] nxt_sy   [NUM_CH];
    logic [HW-1:0]    nxt_xmin [NUM_CH];
    logic [HW-1:0]    nxt_xmax [NUM_CH];
    logic [VW-1:0]    nxt_ymin [NUM_CH];
    logic [VW-1:0]    nxt_ymax [NUM_CH];
    logic             nxt_sat  [NUM_CH];
    logic [SUM_W:0]   sx_sum   [NUM_CH];
    logic [SUM_W:0]   sy_sum   [NUM_CH];

    logic [CNT_W-1:0] sh_cnt   [NUM_CH];
    logic [SUM_W-1:0] sh_sx    [NUM_CH];
    logic [SUM_W-1:0] sh_sy    [NUM_CH];
    logic [HW-1:0]    sh_xmin  [NUM_CH];
    logic [HW-1:0]    sh_xmax  [NUM_CH];
    logic [VW-1:0]    sh_ymin  [NUM_CH];
    logic [VW-1:0]    sh_ymax  [NUM_CH];
    ch_stats_t        sh_flags [NUM_CH];

    logic [RW-1:0]    res_q [NJ];
    logic [RW-1:0]    fin_q [NJ];

    logic             div_start;
    logic             div_done;
    logic [SUM_W-1:0] div_a;
    logic [SUM_W-1:0] div_b;
    logic [SUM_W-1:0] div_q;
    logic             unused_q_bits;

    assign busy_out      = (state != ST_IDLE);
    assign unused_q_bits = ^div_q[SUM_W-1:RW];

    // Accumulator next-state includes this cycle's pixel, so a pixel on the
    // frame_done cycle lands in the closing frame's snapshot.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            nxt_cnt[c]  = acc_cnt[c];
            nxt_sx[c]   = acc_sx[c];
            nxt_sy[c]   = acc_sy[c];
            nxt_xmin[c] = acc_xmin[c];
            nxt_xmax[c] = acc_xmax[c];
            nxt_ymin[c] = acc_ymin[c];
            nxt_ymax[c] = acc_ymax[c];
            nxt_sat[c]  = acc_sat[c];
            sx_sum[c]   = {1'b0, acc_sx[c]} + SW1'(hcount_in);
            sy_sum[c]   = {1'b0, acc_sy[c]} + SW1'(vcount_in);
            if (pix_valid_in && hit_in[c]) begin
                if (&acc_cnt[c]) nxt_sat[c] = 1'b1;
                else             nxt_cnt[c] = acc_cnt[c] + CNT_W'(1);
                if (sx_sum[c][SUM_W]) begin
                    nxt_sx[c]  = '1;
                    nxt_sat[c] = 1'b1;
                end else begin
                    nxt_sx[c] = sx_sum[c][SUM_W-1:0];
                end
                if (sy_sum[c][SUM_W]) begin
                    nxt_sy[c]  = '1;
                    nxt_sat[c] = 1'b1;
                end else begin
                    nxt_sy[c] = sy_sum[c][SUM_W-1:0];
                end
                if (hcount_in < acc_xmin[c]) nxt_xmin[c] = hcount_in;
                if (hcount_in > acc_xmax[c]) nxt_xmax[c] = hcount_in;
                if (vcount_in < acc_ymin[c]) nxt_ymin[c] = vcount_in;
                if (vcount_in > acc_ymax[c]) nxt_ymax[c] = vcount_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n || frame_done_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_cnt[c]  <= '0;
                acc_sx[c]   <= '0;
                acc_sy[c]   <= '0;
                acc_xmin[c] <= BBOX_MIN_EMPTY[HW-1:0];
                acc_xmax[c] <= BBOX_MAX_EMPTY[HW-1:0];
                acc_ymin[c] <= BBOX_MIN_EMPTY[VW-1:0];
                acc_ymax[c] <= BBOX_MAX_EMPTY[VW-1:0];
                acc_sat[c]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_cnt[c]  <= nxt_cnt[c];
                acc_sx[c]   <= nxt_sx[c];
                acc_sy[c]   <= nxt_sy[c];
                acc_xmin[c] <= nxt_xmin[c];
                acc_xmax[c] <= nxt_xmax[c];
                acc_ymin[c] <= nxt_ymin[c];
                acc_ymax[c] <= nxt_ymax[c];
                acc_sat[c]  <= nxt_sat[c];
            end
        end
    end

    // Job j divides channel j/2, x axis when j is even, y when odd. The
    // capture of job j and the load of job j+1 share one edge.
    assign ld_job    = load_pending ? job : job + JW'(1);
    assign ld_ch     = ld_job[JW-1:1];
    assign div_start = (state == ST_DIV) && (load_pending || (div_done && job != LAST_JOB));
    assign div_a     = ld_job[0] ? sh_sy[ld_ch] : sh_sx[ld_ch];
    assign div_b     = SUM_W'(sh_cnt[ld_ch]);

    always_comb begin
        for (int j = 0; j < NJ; j++) begin
            fin_q[j] = (JW'(j) == job) ? div_q[RW-1:0] : res_q[j];
        end
    end

    serial_divider #(.W(SUM_W)) u_div (
        .clk      (clk_in),
        .rst_n    (rst_in_n),
        .start    (div_start),
        .dividend (div_a),
        .divisor  (div_b),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state           <= ST_IDLE;
            job             <= '0;
            load_pending    <= 1'b0;
            stats_valid_out <= 1'b0;
            count_out       <= '0;
            mean_x_out      <= '0;
            mean_y_out      <= '0;
            xmin_out        <= '0;
            xmax_out        <= '0;
            ymin_out        <= '0;
            ymax_out        <= '0;
            found_out       <= '0;
            sat_out         <= '0;
            drop_count_out  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sh_cnt[c]   <= '0;
                sh_sx[c]    <= '0;
                sh_sy[c]    <= '0;
                sh_xmin[c]  <= '0;
                sh_xmax[c]  <= '0;
                sh_ymin[c]  <= '0;
                sh_ymax[c]  <= '0;
                sh_flags[c] <= '0;
            end
            for (int j = 0; j < NJ; j++) res_q[j] <= '0;
        end else begin
            if (frame_done_in && state != ST_IDLE) drop_count_out <= drop_count_out + 8'd1;
            case (state)
                ST_IDLE: begin
                    if (frame_done_in) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            sh_cnt[c]         <= nxt_cnt[c];
                            sh_sx[c]          <= nxt_sx[c];
                            sh_sy[c]          <= nxt_sy[c];
                            sh_xmin[c]        <= nxt_xmin[c];
                            sh_xmax[c]        <= nxt_xmax[c];
                            sh_ymin[c]        <= nxt_ymin[c];
                            sh_ymax[c]        <= nxt_ymax[c];
                            sh_flags[c].found <= (nxt_cnt[c] >= min_count_in);
                            sh_flags[c].sat   <= nxt_sat[c];
                            sh_flags[c].empty <= (nxt_cnt[c] == '0);
                        end
                        state        <= ST_DIV;
                        job          <= '0;
                        load_pending <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (load_pending) begin
                        load_pending <= 1'b0;
                    end else if (div_done) begin
                        res_q[job] <= div_q[RW-1:0];
                        if (job == LAST_JOB) begin
                            state           <= ST_PRESENT;
                            stats_valid_out <= 1'b1;
                            for (int c = 0; c < NUM_CH; c++) begin
                                count_out[c*CNT_W +: CNT_W] <= sh_cnt[c];
                                mean_x_out[c*HW +: HW]      <= fin_q[2*c][HW-1:0];
                                mean_y_out[c*VW +: VW]      <= fin_q[2*c+1][VW-1:0];
                                xmin_out[c*HW +: HW]        <= sh_flags[c].empty ? '0 : sh_xmin[c];
                                xmax_out[c*HW +: HW]        <= sh_flags[c].empty ? '0 : sh_xmax[c];
                                ymin_out[c*VW +: VW]        <= sh_flags[c].empty ? '0 : sh_ymin[c];
                                ymax_out[c*VW +: VW]        <= sh_flags[c].empty ? '0 : sh_ymax[c];
                                found_out[c]                <= sh_flags[c].found;
                                sat_out[c]                  <= sh_flags[c].sat;
                            end
                        end else begin
                            job <= job + JW'(1);
                        end
                    end
                end
                ST_PRESENT: begin
                    if (stats_ready_in) begin
                        stats_valid_out <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blob_stats.sv
// Directed bench for blob_stats: expected bundles are queued at frame end and checked when valid rises.
module tb_blob_stats;

    localparam int NUM_CH = 2;
    localparam int HW     = 11;
    localparam int VW     = 10;
    localparam int CNT_W  = 20;
    localparam int SUM_W  = 32;
    localparam int LAT    = 134;

    typedef struct packed {
        logic [NUM_CH*CNT_W-1:0] count;
        logic [NUM_CH*HW-1:0]    mx;
        logic [NUM_CH*VW-1:0]    my;
        logic [NUM_CH*HW-1:0]    xmin;
        logic [NUM_CH*HW-1:0]    xmax;
        logic [NUM_CH*VW-1:0]    ymin;
        logic [NUM_CH*VW-1:0]    ymax;
        logic [NUM_CH-1:0]       found;
        logic [NUM_CH-1:0]       sat;
        int                      lat;
    } exp_t;

    typedef struct packed {
        logic [7:0]           count;
        logic [NUM_CH*HW-1:0] mx;
        logic [NUM_CH*VW-1:0] my;
        logic [NUM_CH-1:0]    found;
        logic [NUM_CH-1:0]    sat;
        int                   lat;
    } s_exp_t;

    // clock / reset
    logic clk_in = 1'b0;
    logic rst_in_n = 1'b0;
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    logic                    pix_valid_in = 1'b0;
    logic [HW-1:0]           hcount_in = '0;
    logic [VW-1:0]           vcount_in = '0;
    logic [NUM_CH-1:0]       hit_in = '0;
    logic                    frame_done_in = 1'b0;
    logic [CNT_W-1:0]        min_count_in = '0;
    logic                    stats_ready_in = 1'b1;
    logic                    stats_valid_out;
    logic [NUM_CH*CNT_W-1:0] count_out;
    logic [NUM_CH*HW-1:0]    mean_x_out, xmin_out, xmax_out;
    logic [NUM_CH*VW-1:0]    mean_y_out, ymin_out, ymax_out;
    logic [NUM_CH-1:0]       found_out, sat_out;
    logic [7:0]              drop_count_out;
    logic                    busy_out;

    logic                    s_pix = 1'b0;
    logic [NUM_CH-1:0]       s_hit = '0;
    logic                    s_fd = 1'b0;
    logic [3:0]              s_min = 4'd1;
    logic                    s_valid, s_busy;
    logic [7:0]              s_count, s_drop;
    logic [NUM_CH*HW-1:0]    s_mx, s_xmin, s_xmax;
    logic [NUM_CH*VW-1:0]    s_my, s_ymin, s_ymax;
    logic [NUM_CH-1:0]       s_found, s_sat;

    blob_stats #(.NUM_CH(NUM_CH), .HW(HW), .VW(VW), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .pix_valid_in(pix_valid_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .hit_in(hit_in),
        .frame_done_in(frame_done_in), .min_count_in(min_count_in),
        .stats_ready_in(stats_ready_in), .stats_valid_out(stats_valid_out),
        .count_out(count_out), .mean_x_out(mean_x_out), .mean_y_out(mean_y_out),
        .xmin_out(xmin_out), .xmax_out(xmax_out), .ymin_out(ymin_out), .ymax_out(ymax_out),
        .found_out(found_out), .sat_out(sat_out), .drop_count_out(drop_count_out),
        .busy_out(busy_out)
    );

    blob_stats #(.NUM_CH(NUM_CH), .HW(HW), .VW(VW), .CNT_W(4), .SUM_W(SUM_W)) dut_s (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .pix_valid_in(s_pix),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .hit_in(s_hit),
        .frame_done_in(s_fd), .min_count_in(s_min),
        .stats_ready_in(stats_ready_in), .stats_valid_out(s_valid),
        .count_out(s_count), .mean_x_out(s_mx), .mean_y_out(s_my),
        .xmin_out(s_xmin), .xmax_out(s_xmax), .ymin_out(s_ymin), .ymax_out(s_ymax),
        .found_out(s_found), .sat_out(s_sat), .drop_count_out(s_drop),
        .busy_out(s_busy)
    );

    // scoreboard state
    int     checks = 0;
    int     errors = 0;
    int     fd_cyc = 0;
    exp_t   exp_q[$];
    s_exp_t s_q[$];
    exp_t   cur, a_exp, e;
    s_exp_t s_cur, se;
    logic   valid_q = 1'b0;
    logic   s_valid_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input bit sel, input bit pv, input logic [1:0] h,
                         input int x, input int y, input bit fd);
        hcount_in = HW'(x);
        vcount_in = VW'(y);
        if (sel) begin
            s_pix = pv; s_hit = h; s_fd = fd;
        end else begin
            pix_valid_in = pv; hit_in = h; frame_done_in = fd;
        end
        if (fd) fd_cyc = cyc;
        step();
        pix_valid_in = 1'b0; hit_in = '0; frame_done_in = 1'b0;
        s_pix = 1'b0; s_hit = '0; s_fd = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? (s_busy || s_valid) : (busy_out || stats_valid_out)) && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL idle_timeout got busy expected idle (cycle %0d)", cyc);
        end
    endtask

    task automatic new_exp();
        cur = '0;
    endtask

    task automatic set_ch(input int c, input int cnt, input int mx, input int my,
                          input int x0, input int x1, input int y0, input int y1, input bit f);
        cur.count[c*CNT_W +: CNT_W] = CNT_W'(cnt);
        cur.mx[c*HW +: HW]   = HW'(mx);
        cur.my[c*VW +: VW]   = VW'(my);
        cur.xmin[c*HW +: HW] = HW'(x0);
        cur.xmax[c*HW +: HW] = HW'(x1);
        cur.ymin[c*VW +: VW] = VW'(y0);
        cur.ymax[c*VW +: VW] = VW'(y1);
        cur.found[c] = f;
    endtask

    task automatic push_exp();
        cur.lat = fd_cyc + LAT;
        exp_q.push_back(cur);
    endtask

    // monitors
    always @(negedge clk_in) begin
        if (!rst_in_n) begin
            valid_q = 1'b0;
        end else begin
            if (stats_valid_out && !valid_q) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency", 64'(cyc), 64'(e.lat));
                    chk("count", count_out, e.count);
                    chk("mean_x", mean_x_out, e.mx);
                    chk("mean_y", mean_y_out, e.my);
                    chk("xmin", xmin_out, e.xmin);
                    chk("xmax", xmax_out, e.xmax);
                    chk("ymin", ymin_out, e.ymin);
                    chk("ymax", ymax_out, e.ymax);
                    chk("found", found_out, e.found);
                    chk("sat", sat_out, e.sat);
                end
            end
            valid_q = stats_valid_out;
        end
    end

    always @(negedge clk_in) begin
        if (!rst_in_n) begin
            s_valid_q = 1'b0;
        end else begin
            if (s_valid && !s_valid_q) begin
                if (s_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL s_unexpected_valid got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    se = s_q.pop_front();
                    chk("s_latency", 64'(cyc), 64'(se.lat));
                    chk("s_count", s_count, se.count);
                    chk("s_mean_x", s_mx, se.mx);
                    chk("s_mean_y", s_my, se.my);
                    chk("s_found", s_found, se.found);
                    chk("s_sat", s_sat, se.sat);
                end
            end
            s_valid_q = s_valid;
        end
    end

    initial begin
        int n;
        repeat (3) step();
        chk("rst_valid", stats_valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_count", count_out, 0);
        chk("rst_mean_x", mean_x_out, 0);
        chk("rst_xmin", xmin_out, 0);
        chk("rst_found", found_out, 0);
        chk("rst_sat", sat_out, 0);
        chk("rst_drop", drop_count_out, 0);
        rst_in_n = 1'b1;
        step();

        // single ch0 hit
        min_count_in = 20'd1;
        drive(0, 1, 2'b01, 100, 50, 0);
        drive(0, 0, 2'b00, 0, 0, 1);
        new_exp();
        set_ch(0, 1, 100, 50, 100, 100, 50, 50, 1);
        push_exp();
        wait_idle(0);

        // ch1 2x2 square, last pixel on the frame_done cycle; found at count == min
        min_count_in = 20'd4;
        drive(0, 1, 2'b10, 10, 10, 0);
        drive(0, 1, 2'b10, 11, 10, 0);
        drive(0, 1, 2'b10, 10, 11, 0);
        drive(0, 1, 2'b10, 11, 11, 1);
        new_exp();
        set_ch(1, 4, 10, 10, 10, 11, 10, 11, 1);
        push_exp();
        wait_idle(0);

        // empty frame
        min_count_in = 20'd1;
        drive(0, 0, 2'b00, 0, 0, 1);
        new_exp();
        push_exp();
        wait_idle(0);

        // backpressure: a frame_done during PRESENT is dropped
        stats_ready_in = 1'b0;
        drive(0, 1, 2'b01, 5, 6, 0);
        drive(0, 1, 2'b01, 7, 8, 0);
        drive(0, 0, 2'b00, 0, 0, 1);
        new_exp();
        set_ch(0, 2, 6, 7, 5, 7, 6, 8, 1);
        a_exp = cur;
        push_exp();
        n = 0;
        while (!stats_valid_out && n < 300) begin
            step();
            n++;
        end
        chk("valid_timeout", 64'(n < 300), 1);
        drive(0, 1, 2'b01, 1, 1, 1);
        repeat (3) step();
        chk("drop_count", drop_count_out, 1);
        chk("hold_valid", stats_valid_out, 1);
        chk("hold_count", count_out, a_exp.count);
        chk("hold_mean_x", mean_x_out, a_exp.mx);
        chk("hold_xmax", xmax_out, a_exp.xmax);
        stats_ready_in = 1'b1;
        step();
        chk("valid_after_hs", stats_valid_out, 0);
        wait_idle(0);
        chk("hold_after_hs", count_out, a_exp.count);

        min_count_in = 20'd2;
        drive(0, 1, 2'b10, 200, 300, 0);
        drive(0, 0, 2'b00, 0, 0, 1);
        new_exp();
        set_ch(1, 1, 200, 300, 200, 200, 300, 300, 0);
        push_exp();
        wait_idle(0);

        // saturating counter on the CNT_W=4 instance
        repeat (20) drive(1, 1, 2'b01, 5, 5, 0);
        drive(1, 0, 2'b00, 0, 0, 1);
        s_cur = '0;
        s_cur.count = 8'h0F; s_cur.mx = 22'd6; s_cur.my = 20'd6;
        s_cur.found = 2'b01; s_cur.sat = 2'b01; s_cur.lat = fd_cyc + LAT;
        s_q.push_back(s_cur);
        wait_idle(1);
        repeat (3) drive(1, 1, 2'b01, 5, 5, 0);
        drive(1, 0, 2'b00, 0, 0, 1);
        s_cur = '0;
        s_cur.count = 8'h03; s_cur.mx = 22'd5; s_cur.my = 20'd5;
        s_cur.found = 2'b01; s_cur.sat = 2'b00; s_cur.lat = fd_cyc + LAT;
        s_q.push_back(s_cur);
        wait_idle(1);

        // reset in the middle of DIV discards the frame
        drive(0, 1, 2'b01, 30, 40, 0);
        drive(0, 0, 2'b00, 0, 0, 1);
        repeat (40) step();
        chk("busy_in_div", busy_out, 1);
        rst_in_n = 1'b0;
        step();
        step();
        chk("mid_rst_valid", stats_valid_out, 0);
        chk("mid_rst_busy", busy_out, 0);
        chk("mid_rst_count", count_out, 0);
        chk("mid_rst_mean_y", mean_y_out, 0);
        chk("mid_rst_ymax", ymax_out, 0);
        chk("mid_rst_drop", drop_count_out, 0);
        rst_in_n = 1'b1;
        repeat (200) step();
        chk("no_valid_after_rst", stats_valid_out, 0);

        min_count_in = 20'd1;
        drive(0, 1, 2'b01, 1, 2, 0);
        drive(0, 0, 2'b00, 0, 0, 1);
        new_exp();
        set_ch(0, 1, 1, 2, 1, 1, 2, 2, 1);
        push_exp();
        wait_idle(0);

        step();
        chk("exp_q_empty", 64'(exp_q.size()), 0);
        chk("s_q_empty", 64'(s_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
